// File: rtl/mem_writer_if.sv
// Stream-in / memory-write-out bundle for mem_writer: valid/ready data input
// plus the single-port write strobe, address and data going to the BRAM.
interface mem_writer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  write_en,
        input  write_address,
        input  write_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output write_en,
        output write_address,
        output write_data
    );
endinterface

// File: rtl/mem_writer.sv
// Converts a valid/ready stream into a burst of single-port memory writes,
// armed by start_writing with a wrapping address and a one-cycle done pulse.
module mem_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MEM_SIZE   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_writing,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [ADDR_WIDTH:0]   num_words,
    mem_writer_if.slave           bus,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   MEM_SIZE_W = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_SIZE - 1);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH:0]   target_reg, target_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic                  write_en_reg, write_en_next;
    logic [ADDR_WIDTH-1:0] write_address_reg, write_address_next;
    logic [DATA_WIDTH-1:0] write_data_reg, write_data_next;
    logic                  in_ready;
    logic                  beat;

    // abort wins over a pending beat so a cancelled cycle never writes
    assign in_ready = (state_reg == WRITE) && !abort;
    assign beat     = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            target_reg        <= '0;
            count_reg         <= '0;
            write_en_reg      <= 1'b0;
            write_address_reg <= '0;
            write_data_reg    <= '0;
        end else begin
            state_reg         <= state_next;
            addr_reg          <= addr_next;
            target_reg        <= target_next;
            count_reg         <= count_next;
            write_en_reg      <= write_en_next;
            write_address_reg <= write_address_next;
            write_data_reg    <= write_data_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        addr_next          = addr_reg;
        target_next        = target_reg;
        count_next         = count_reg;
        write_en_next      = 1'b0;
        write_address_next = write_address_reg;
        write_data_next    = write_data_reg;
        case (state_reg)
            IDLE: begin
                if (start_writing && (num_words != '0)) begin
                    addr_next   = base_address;
                    target_next = (num_words > MEM_SIZE_W) ? MEM_SIZE_W : num_words;
                    count_next  = '0;
                    state_next  = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (beat) begin
                    write_en_next      = 1'b1;
                    write_address_next = addr_reg;
                    write_data_next    = bus.in_data;
                    addr_next          = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
                    count_next         = count_reg + 1'b1;
                    if (count_next == target_reg) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // DONE is entered on the same edge that launches the final strobe
    assign done              = (state_reg == DONE);
    assign busy              = (state_reg == WRITE) || (state_reg == DONE);
    assign words_written     = count_reg;
    assign bus.in_ready      = in_ready;
    assign bus.write_en      = write_en_reg;
    assign bus.write_address = write_address_reg;
    assign bus.write_data    = write_data_reg;
endmodule
